// File: rtl/lsu_mem_queue.sv
// lsu_mem_queue
// Load/store request unit between the execute stage and the data-side
// SRAM-like bus. Accepted requests wait in a one-entry issue register until
// the bus takes them (addr_ok). They then sit in an in-order queue of up to
// DEPTH entries until their data_ok returns. Store strobes and data are
// formatted on the way out. Load data is aligned and extended on the way back.
// A flush silently drops the responses of every request already accepted.
//
// Optional feature macro: LSU_ALE_CHECK_EN
//   When it is defined, a misaligned half or word access is never sent to the
//   bus. Once the queue has drained, it is answered locally with resp_ale = 1.
//
// Ports
//   clk, rstn                      clock, asynchronous active-low reset
//   req_valid/req_ready            upstream handshake
//   req_wr/size/signed/addr/wdata/tag  request payload
//   flush                          kill every accepted, unreturned request
//   data_sram_*                    bus request / response channel
//   resp_valid/wr/tag/rdata/ale    one-cycle response pulse (no backpressure)
//   busy                           issue register or queue occupied
module lsu_mem_queue #(
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic              flush,
   output logic              data_sram_req,
   output logic              data_sram_wr,
   output logic [1:0]        data_sram_size,
   output logic [3:0]        data_sram_wstrb,
   output logic [ADDR_W-1:0] data_sram_addr,
   output logic [31:0]       data_sram_wdata,
   input  logic              data_sram_addr_ok,
   input  logic              data_sram_data_ok,
   input  logic [31:0]       data_sram_rdata,
   output logic              resp_valid,
   output logic              resp_wr,
   output logic [TAG_W-1:0]  resp_tag,
   output logic [31:0]       resp_rdata,
   output logic              resp_ale,
   output logic              busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // Issue register
   logic              iss_v;
   logic              iss_wr;
   logic [1:0]        iss_size;
   logic              iss_signed;
   logic [ADDR_W-1:0] iss_addr;
   logic [31:0]       iss_wdata;
   logic [TAG_W-1:0]  iss_tag;

   // In-flight queue
   logic             q_wr     [DEPTH];
   logic [1:0]       q_size   [DEPTH];
   logic             q_signed [DEPTH];
   logic [1:0]       q_addr   [DEPTH];
   logic [TAG_W-1:0] q_tag    [DEPTH];
   logic             q_killed [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;

   logic ale_pending;
   logic ale_fire;
   logic push;
   logic pop;
   logic accept;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      next_ptr = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

`ifdef LSU_ALE_CHECK_EN
   logic iss_ale;
   logic req_misaligned;

   // Misalignment is decided at acceptance. The flag is only meaningful
   // while iss_v is set.
   always_comb begin
      req_misaligned = 1'b0;
      if (req_size == 2'd1)
         req_misaligned = req_addr[0];
      else if (req_size == 2'd2)
         req_misaligned = (req_addr[1:0] != 2'b00);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         iss_ale <= 1'b0;
      else if (accept)
         iss_ale <= req_misaligned;
   end

   assign ale_pending = iss_v && iss_ale;
`else
   assign ale_pending = 1'b0;
`endif

   // The local ALE answer waits for an empty queue, so responses stay in order.
   assign ale_fire      = ale_pending && (cnt == '0) && !flush;
   assign data_sram_req = iss_v && (cnt != FULL) && !ale_pending;
   assign push          = data_sram_req && data_sram_addr_ok;
   assign pop           = data_sram_data_ok && (cnt != '0);
   assign req_ready     = !flush && (!iss_v || push);
   assign accept        = req_valid && req_ready;
   assign busy          = iss_v || (cnt != '0);

   // Bus request fields come only from the issue register.
   always_comb begin
      data_sram_wr    = iss_wr;
      data_sram_size  = iss_size;
      data_sram_addr  = iss_addr;
      data_sram_wstrb = 4'b0000;
      data_sram_wdata = 32'h0;
      if (iss_wr) begin
         case (iss_size)
            2'd0: begin
               data_sram_wstrb = 4'b0001 << iss_addr[1:0];
               data_sram_wdata = {4{iss_wdata[7:0]}};
            end
            2'd1: begin
               data_sram_wstrb = iss_addr[1] ? 4'b1100 : 4'b0011;
               data_sram_wdata = {2{iss_wdata[15:0]}};
            end
            default: begin
               data_sram_wstrb = 4'b1111;
               data_sram_wdata = iss_wdata;
            end
         endcase
      end
   end

   // Response path: head of queue on data_ok, or a locally generated ALE.
   logic [31:0] shifted;
   logic [31:0] load_val;
   always_comb begin
      shifted = data_sram_rdata >> {q_addr[rd_ptr], 3'b000};
      case (q_size[rd_ptr])
         2'd0:    load_val = {{24{shifted[7] & q_signed[rd_ptr]}}, shifted[7:0]};
         2'd1:    load_val = {{16{shifted[15] & q_signed[rd_ptr]}}, shifted[15:0]};
         default: load_val = data_sram_rdata;
      endcase
      resp_valid = (pop && !q_killed[rd_ptr]) || ale_fire;
      resp_ale   = ale_fire;
      resp_wr    = ale_fire ? iss_wr  : q_wr[rd_ptr];
      resp_tag   = ale_fire ? iss_tag : q_tag[rd_ptr];
      resp_rdata = (ale_fire || q_wr[rd_ptr]) ? 32'h0 : load_val;
   end

   // Queue and issue register state. A flush marks every slot killed. The
   // entry pushed in the same cycle is written afterwards with killed = flush.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         iss_v      <= 1'b0;
         iss_wr     <= 1'b0;
         iss_size   <= 2'd0;
         iss_signed <= 1'b0;
         iss_addr   <= '0;
         iss_wdata  <= 32'h0;
         iss_tag    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_wr[i]     <= 1'b0;
            q_size[i]   <= 2'd0;
            q_signed[i] <= 1'b0;
            q_addr[i]   <= 2'd0;
            q_tag[i]    <= '0;
            q_killed[i] <= 1'b0;
         end
      end else begin
         if (flush)
            for (int i = 0; i < DEPTH; i++)
               q_killed[i] <= 1'b1;
         if (push) begin
            q_wr[wr_ptr]     <= iss_wr;
            q_size[wr_ptr]   <= iss_size;
            q_signed[wr_ptr] <= iss_signed;
            q_addr[wr_ptr]   <= iss_addr[1:0];
            q_tag[wr_ptr]    <= iss_tag;
            q_killed[wr_ptr] <= flush;
            wr_ptr           <= next_ptr(wr_ptr);
         end
         if (pop)
            rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)
            cnt <= cnt + CW'(1);
         else if (pop && !push)
            cnt <= cnt - CW'(1);

         if (flush)
            iss_v <= 1'b0;
         else if (accept) begin
            iss_v      <= 1'b1;
            iss_wr     <= req_wr;
            iss_size   <= req_size;
            iss_signed <= req_signed;
            iss_addr   <= req_addr;
            iss_wdata  <= req_wdata;
            iss_tag    <= req_tag;
         end else if (push || ale_fire)
            iss_v <= 1'b0;
      end
   end

endmodule
